// File: rtl/wb_write_queue.sv
// Four-entry write-back queue merging pipeline (A) and multi-cycle (B) register writes.
// Optional: define WB_TRACE_EN to print one trace line per retired register write.
module wb_write_queue (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [31:0] a_pc,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [31:0] b_pc,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    input  logic        wb_hold,
    output logic        reg_write,
    output logic [31:0] pc,
    output logic [4:0]  reg_addr,
    output logic [31:0] reg_data,
    input  logic [4:0]  q1_addr,
    output logic        q1_busy,
    input  logic [4:0]  q2_addr,
    output logic        q2_busy,
    output logic [2:0]  count,
    output logic        full,
    output logic        empty
);
    localparam int DEPTH = 4;

    logic [31:0]      pc_mem   [DEPTH];
    logic [4:0]       addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [1:0]       wr_ptr, rd_ptr;
    logic [2:0]       occ;
    logic             a_fire, b_fire, enq, deq;
    logic [31:0]      enq_pc, enq_data;
    logic [4:0]       enq_addr;
    logic [DEPTH-1:0] live;

    assign count   = occ;
    assign full    = (occ == 3'd4);
    assign empty   = (occ == 3'd0);
    assign a_ready = !full;
    assign b_ready = !full && !a_valid;
    assign a_fire  = a_valid && a_ready;
    assign b_fire  = b_valid && b_ready;

    // Writes to $0 finish the handshake but are dropped before the queue.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        enq_pc   = a_pc;
        enq_addr = a_addr;
        enq_data = a_data;
        if (!a_fire) begin
            enq_pc   = b_pc;
            enq_addr = b_addr;
            enq_data = b_data;
        end
        enq = (a_fire || b_fire) && (enq_addr != 5'd0);
    end

    assign reg_write = !empty && !wb_hold;
    assign deq       = reg_write;
    assign pc        = reg_write ? pc_mem[rd_ptr]   : '0;
    assign reg_addr  = reg_write ? addr_mem[rd_ptr] : '0;
    assign reg_data  = reg_write ? data_mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 3'd0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 2'd1;
            if (deq) rd_ptr <= rd_ptr + 2'd1;
            case ({enq, deq})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

    // NOTE: entry storage has no reset; every consumer is gated by occupancy.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr]   <= enq_pc;
            addr_mem[wr_ptr] <= enq_addr;
            data_mem[wr_ptr] <= enq_data;
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        live    = '0;
        q1_busy = 1'b0;
        q2_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = ({1'b0, 2'(i) - rd_ptr} < occ);
            if (live[i] && (q1_addr != 5'd0) && (addr_mem[i] == q1_addr)) q1_busy = 1'b1;
            if (live[i] && (q2_addr != 5'd0) && (addr_mem[i] == q2_addr)) q2_busy = 1'b1;
        end
    end

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && reg_write)
            $display("@%08h: $%0d <= %08h", pc, reg_addr, reg_data);
    end
`endif

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset: "reset" is asserted at 0, takes effect without a clock edge, and is released synchronously to clk.
REQ-002 The block SHALL expose these ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset
- a_valid  in  1  pipeline write-back request
- a_ready  out  1  port A accepted
- a_pc  in  32  pipeline instruction PC
- a_addr  in  5  pipeline destination register
- a_data  in  32  pipeline write data
- b_valid  in  1  multi-cycle unit request
- b_ready  out  1  port B accepted
- b_pc  in  32  multi-cycle instruction PC
- b_addr  in  5  multi-cycle destination register
- b_data  in  32  multi-cycle write data
- wb_hold  in  1  suppress drain this cycle
- reg_write  out  1  write enable to register file
- pc  out  32  PC of the write being drained
- reg_addr  out  5  destination register to register file
- reg_data  out  32  write data to register file
- q1_addr  in  5  hazard query address 1
- q1_busy  out  1  write to q1_addr pending
- q2_addr  in  5  hazard query address 2
- q2_busy  out  1  write to q2_addr pending
- count  out  3  occupied entries, 0..4
- full  out  1  count == 4
- empty  out  1  count == 0

Function
REQ-003 The block SHALL hold a 4-entry FIFO; each entry is {pc[31:0], addr[4:0], data[31:0]}.
REQ-004 Each source SHALL use a valid/ready handshake; a transfer occurs on a rising clk edge when valid and ready are both 1.
REQ-005 a_ready SHALL equal !full.
REQ-006 b_ready SHALL equal !full && !a_valid, so that port A has strict priority and at most one entry is enqueued per cycle.
REQ-007 A transfer with addr == 0 SHALL complete the handshake but SHALL NOT be enqueued; count does not change.
REQ-008 reg_write SHALL equal !empty && !wb_hold, combinationally.
REQ-009 While reg_write is 1, {pc, reg_addr, reg_data} SHALL present the head entry. While reg_write is 0, these outputs SHALL be 0.
REQ-010 The head entry SHALL dequeue on every rising edge where reg_write is 1.
REQ-011 Latency: an entry enqueued at edge N into an empty FIFO with wb_hold=0 SHALL appear with reg_write=1 during cycle N+1 and SHALL be retired at edge N+1.
REQ-012 Entries SHALL drain in strict acceptance order.
REQ-013 If an enqueue and a dequeue occur on the same edge, count SHALL be unchanged and both operations SHALL take effect.
REQ-014 When full, no transfer SHALL occur, even if a dequeue happens on the same edge; there is no pass-through.
REQ-015 The read and write pointers SHALL each be 2 bits and wrap 3 -> 0.
REQ-016 qN_busy SHALL be 1 iff qN_addr != 0 and any occupied entry has addr == qN_addr, combinationally. The head entry counts as occupied until its dequeue edge.
REQ-017 full, empty and count SHALL reflect registered occupancy only.

Reset
REQ-018 When reset is 0, the block SHALL set count=0, both pointers=0, reg_write=0, pc/reg_addr/reg_data=0, q1_busy=q2_busy=0, empty=1, full=0 and a_ready=1, regardless of clk.
REQ-019 A reset asserted while entries are pending SHALL discard all entries, and no write SHALL be issued for them.
REQ-020 Entry storage SHALL NOT need to be reset; all outputs are gated by occupancy.

Configuration
REQ-021 With the macro WB_TRACE_EN defined, each rising edge where reg_write=1 and reset=1 SHALL print "@<pc 8 hex>: $<reg_addr decimal> <= <reg_data 8 hex>", with 8 hex digits zero-padded.
REQ-022 Without WB_TRACE_EN, the block SHALL contain no display statements and its behaviour SHALL be otherwise identical.

Verification
REQ-023 A bench SHALL cover at least these scenarios:
- Reset released; a_valid=1, a_pc=0x3000, a_addr=8, a_data=0x12345678 for one cycle -> the next cycle shows reg_write=1, pc=0x3000, reg_addr=8, reg_data=0x12345678; count returns to 0 after that edge.
- wb_hold=1; five consecutive port A writes to $1..$5 -> the first four are accepted and the fifth waits with a_ready=0; full=1 and count=4. Release wb_hold -> writes drain $1,$2,$3,$4,$5 in order.
- a_valid and b_valid both 1 for one cycle -> a_ready=1, b_ready=0; port A is enqueued, and port B is accepted the next cycle.
- a_addr=0 with a_valid=1 -> a_ready=1, count stays 0, and reg_write never asserts.
- wb_hold=1; enqueue a write to $9; q1_addr=9 -> q1_busy=1. Set q2_addr=0 -> q2_busy=0. Release hold -> q1_busy falls after the drain edge.
- Three entries pending; pulse reset low mid-cycle -> count=0 and reg_write=0 immediately, and no pending write is ever issued.
